// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate generator for the decode stage.
// Extracts the I/S/B/J/U/shamt immediates selected by imm_src, extends them to
// XLEN bits and carries a sideband tag. A 2-entry (output + skid) buffer with
// valid/ready handshakes on both sides never drops an instruction under
// back-pressure. in_ready is register-derived and has no combinational path
// from out_ready.
// Optional feature: define IMM_GEN_ZIMM_EN to decode imm_src 3'b110 as the CSR
// zimm (instr[19:15] zero-extended). Without it, 3'b110 yields zero.

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  imm_new;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_valid_q;
    logic             accept;
    logic             out_free;

    // The opcode field is never inspected; format comes from imm_src only.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Extract and extend the immediate selected by imm_src.
    // Signed size casts give sign extension to XLEN for any legal XLEN.
    always_comb begin
        imm_new = '0;
        case (imm_src)
            3'b000: imm_new = XLEN'($signed(instr[31:20]));
            3'b001: imm_new = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: imm_new = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0}));
            3'b011: imm_new = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                              instr[30:21], 1'b0}));
            3'b100: imm_new = XLEN'($signed({instr[31:12], 12'b0}));
            // RV64 shamt is 6 bits wide; RV32 ignores instr[25].
            3'b101: imm_new = XLEN'({(XLEN == 64) && instr[25], instr[24:20]});
`ifdef IMM_GEN_ZIMM_EN
            3'b110: imm_new = XLEN'(instr[19:15]);
`else
            3'b110: imm_new = '0;
`endif
            default: imm_new = '0;
        endcase
    end

    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign out_free  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign imm_out   = out_imm_q;
    assign out_tag   = out_tag_q;

    // Output/skid buffer update; flush outranks every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_imm_q    <= skid_imm_q;
                out_tag_q    <= skid_tag_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= imm_new;
                out_tag_q   <= in_tag;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_imm_q   <= imm_new;
            skid_tag_q   <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical
// stimulus and compares both against a queue-based reference model that
// computes immediates arithmetically from the instruction fields.
module tb_imm_gen_pipe;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      instr = '0;
    logic [2:0]       imm_src = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             rdy32, rdy64, ov32, ov64;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag32, tag64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]      e32;
        logic [63:0]      e64;
        logic [TAG_W-1:0] tag;
    } ent_t;
    ent_t q[$];

    localparam longint TWO12 = 64'sd4096;
    localparam longint TWO13 = 64'sd8192;
    localparam longint TWO21 = 64'sd2097152;
    localparam longint TWO32 = 64'sh1_0000_0000;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy32), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .imm_out(imm32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy64), .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .imm_out(imm64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate value from the ISA field definitions, using integer arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input int xlen);
        longint v;
        v = 0;
        case (src)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v -= TWO12;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= TWO12;
            end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= TWO13;
            end
            3'd3: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v -= TWO21;
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= TWO32;
            end
            3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
`ifdef IMM_GEN_ZIMM_EN
            3'd6: v = longint'(ins[19:15]);
`else
            3'd6: v = 0;
`endif
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    // Compare both instances against the model's current occupancy/head.
    task automatic compare();
        check("in_ready32", {63'b0, rdy32}, {63'b0, q.size() < 2});
        check("in_ready64", {63'b0, rdy64}, {63'b0, q.size() < 2});
        check("out_valid32", {63'b0, ov32}, {63'b0, q.size() != 0});
        check("out_valid64", {63'b0, ov64}, {63'b0, q.size() != 0});
        if (q.size() != 0) begin
            check("imm32", {32'b0, imm32}, q[0].e32);
            check("imm64", imm64, q[0].e64);
            check("tag32", {{(64-TAG_W){1'b0}}, tag32}, {{(64-TAG_W){1'b0}}, q[0].tag});
            check("tag64", {{(64-TAG_W){1'b0}}, tag64}, {{(64-TAG_W){1'b0}}, q[0].tag});
        end
    endtask

    // Advance the model by one clock using the inputs now applied, then check.
    task automatic step();
        bit   acc;
        ent_t e;
        acc = in_valid && (q.size() < 2) && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.e32 = ref_imm(instr, imm_src, 32);
                e.e64 = ref_imm(instr, imm_src, 64);
                e.tag = in_tag;
                q.push_back(e);
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] t);
        in_valid  = 1'b1;
        instr     = ins;
        imm_src   = src;
        in_tag    = t;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {62'b0, ov32, ov64}, 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_tag32", {56'b0, tag32}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        compare();
        check("rst_in_ready", {62'b0, rdy32, rdy64}, 64'd3);

        // Directed formats, one cycle after accept
        send(32'hFFF00093, 3'd0, 8'h10);
        check("I", {32'b0, imm32}, 64'hFFFF_FFFF);
        send(32'hFE112E23, 3'd1, 8'h11);
        check("S", {32'b0, imm32}, 64'hFFFF_FFFC);
        send(32'hFE000EE3, 3'd2, 8'h12);
        check("B", {32'b0, imm32}, 64'hFFFF_FFFC);
        send(32'hFFDFF06F, 3'd3, 8'h13);
        check("J", {32'b0, imm32}, 64'hFFFF_FFFC);
        send(32'h123450B7, 3'd4, 8'h14);
        check("U", {32'b0, imm32}, 64'h1234_5000);
        send(32'hFFFFFFFF, 3'd7, 8'h15);
        check("RSV", {32'b0, imm32}, 64'h0);
        check("RSV64", imm64, 64'h0);
        send(32'h800000B7, 3'd4, 8'h16);
        check("U64", imm64, 64'hFFFF_FFFF_8000_0000);
        send(32'h03F00013, 3'd5, 8'h17);
        check("SHAMT64", imm64, 64'h3F);
        check("SHAMT32", {32'b0, imm32}, 64'h1F);
        send(32'h000F8073, 3'd6, 8'h18);
`ifdef IMM_GEN_ZIMM_EN
        check("ZIMM", imm64, 64'h1F);
`else
        check("ZIMM", imm64, 64'h0);
`endif
        out_ready = 1'b1;
        step();

        // Back-pressure: tags 1, 2, 3 back-to-back with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        imm_src   = 3'd0;
        in_tag    = 8'd1;
        step();
        check("bp_ready1", {63'b0, rdy32}, 64'd1);
        in_tag = 8'd2;
        step();
        check("bp_ready2", {63'b0, rdy32}, 64'd0);
        in_tag = 8'd3;
        step();
        check("bp_hold_tag", {56'b0, tag32}, 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_out2", {56'b0, tag32}, 64'd2);
        step();
        check("bp_out3", {56'b0, tag64}, 64'd3);
        in_valid = 1'b0;
        step();
        check("bp_drained", {63'b0, ov32}, 64'd0);

        // Flush with both entries full and a word presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'hA1;
        step();
        in_tag = 8'hA2;
        step();
        in_tag = 8'hA3;
        flush  = 1'b1;
        step();
        check("flush_valid", {62'b0, ov32, ov64}, 64'd0);
        check("flush_ready", {62'b0, rdy32, rdy64}, 64'd3);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_nocap", {63'b0, ov32}, 64'd0);

        // Randomized traffic with an asynchronous reset partway through
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 39) == 0);
            if (i == 700) begin
                out_ready = 1'b0;
                flush     = 1'b0;
                in_valid  = 1'b1;
                step();
                #2 rst_n = 1'b0;
                #1;
                check("arst_valid", {62'b0, ov32, ov64}, 64'd0);
                check("arst_imm", {imm64[63:32], imm64[31:0] | imm32}, 64'd0);
                check("arst_tag", {48'b0, tag32, tag64}, 64'd0);
                q.delete();
                in_valid = 1'b0;
                flush    = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                compare();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
